// File: rtl/newcell_dmem_ctrl.sv
// Newcell data-memory controller: one load/store at a time, WAIT_CYCLES wait states, byte/half/word lanes.
// Latency: response valid WAIT_CYCLES+1 cycles after the accept cycle; one request in flight at a time.
// Backpressure: req_ready drops while busy; the response is held with all outputs frozen until rsp_ready.
// Optional feature macro: NEWCELL_DMEM_MISALIGN_ERR_EN (fault misaligned half/word instead of aligning them).
module newcell_dmem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_sign_ext,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // Counter never needs to hold more than WAIT_CYCLES-1; keep one bit when there are no wait states.
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT  = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              sx_q, sx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic              do_access;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [1:0]        acc_size;
  logic              acc_sx;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-1:0] acc_idx_full;
  logic              acc_err;
  logic [1:0]        lane;
  logic [IDX_W-1:0]  mem_idx;
  logic [31:0]       rd_word;
  logic [31:0]       shifted;
  logic [31:0]       load_val;
  logic [3:0]        wr_be;
  logic [31:0]       wr_dat;
  logic              mem_we;

  assign req_ready = rst && (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Access operands: live request fields when accessing straight from IDLE, latched fields otherwise.
  always_comb begin
    acc_wr       = wr_q;
    acc_addr     = addr_q;
    acc_size     = size_q;
    acc_sx       = sx_q;
    acc_wdata    = wdata_q;
    if (state_q == S_IDLE) begin
      acc_wr    = req_wr;
      acc_addr  = req_addr;
      acc_size  = req_size;
      acc_sx    = req_sign_ext;
      acc_wdata = req_wdata;
    end
    acc_idx_full = {2'b00, acc_addr[ADDR_W-1:2]};
    mem_idx      = acc_addr[IDX_W+1:2];
`ifdef NEWCELL_DMEM_MISALIGN_ERR_EN
    lane    = acc_addr[1:0];
    acc_err = (acc_size == 2'b11) || (acc_idx_full >= DEPTH_LIM) ||
              ((acc_size == 2'b01) && acc_addr[0]) ||
              ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00));
`else
    // Misaligned half/word accesses silently round down to their natural boundary.
    case (acc_size)
      2'b01:   lane = {acc_addr[1], 1'b0};
      2'b10:   lane = 2'b00;
      default: lane = acc_addr[1:0];
    endcase
    acc_err = (acc_size == 2'b11) || (acc_idx_full >= DEPTH_LIM);
`endif
  end

  // Load path: pick the addressed lane, move it to bit 0 and extend to 32 bits.
  always_comb begin
    rd_word  = mem[mem_idx];
    shifted  = rd_word >> {lane, 3'b000};
    load_val = shifted;
    case (acc_size)
      2'b00:   load_val = {{24{acc_sx & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{acc_sx & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Store path: replicate right-aligned data into every lane and enable only the addressed bytes.
  always_comb begin
    wr_be  = 4'b0000;
    wr_dat = acc_wdata;
    case (acc_size)
      2'b00: begin
        wr_be  = 4'b0001 << lane;
        wr_dat = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        wr_be  = lane[1] ? 4'b1100 : 4'b0011;
        wr_dat = {2{acc_wdata[15:0]}};
      end
      2'b10: begin
        wr_be  = 4'b1111;
        wr_dat = acc_wdata;
      end
      default: begin
        wr_be  = 4'b0000;
        wr_dat = acc_wdata;
      end
    endcase
  end

  // Next-state logic: accept in IDLE, count down wait states, access on entry to RESP, hold until taken.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    size_d    = size_q;
    sx_d      = sx_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          size_d  = req_size;
          sx_d    = req_sign_ext;
          wdata_d = req_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d   = S_RESP;
            do_access = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d   = S_RESP;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (do_access) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_wr) ? 32'h0 : load_val;
    end
  end

  // A store commits only on a clean access outside reset, so an aborted request leaves RAM untouched.
  assign mem_we = rst && do_access && acc_wr && !acc_err;

  // State and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      sx_q    <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sx_q    <= sx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM byte-lane writes; contents are deliberately not touched by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[mem_idx][8*b +: 8] <= wr_dat[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_newcell_dmem_ctrl.sv
// Bench for newcell_dmem_ctrl: directed scenarios followed by random traffic against a byte-array model.
// Timing: inputs driven from one initial block, outputs sampled 1 time unit after the rising edge.
// Backpressure: optional rsp_ready stall per transaction with a competing request held on the port.
module tb_newcell_dmem_ctrl;

  localparam int WAIT  = 2;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_sign_ext;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Reference memory as a flat little-endian byte array.
  logic [7:0] mb [0:4*DEPTH-1];

  newcell_dmem_ctrl #(
    .ADDR_W      (32),
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_sign_ext (req_sign_ext),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model: size gives a byte count, errors are decided from byte address arithmetic.
  task automatic model(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic sx, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] a;
    logic [31:0] v;
    rd = 32'h0;
    er = 1'b0;
    n  = 1 << size;
    if (size == 2'd3) er = 1'b1;
    if (addr >= 32'(4*DEPTH)) er = 1'b1;
`ifdef NEWCELL_DMEM_MISALIGN_ERR_EN
    if (size != 2'd3 && (addr % n) != 0) er = 1'b1;
`endif
    if (!er) begin
      a = addr - (addr % n);
      if (wr) begin
        for (int i = 0; i < n; i++) mb[a+i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mb[a+i];
        if (sx && v[8*n-1]) begin
          for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        rd = v;
      end
    end
  endtask

  // One complete transaction; bp>0 stalls the response and offers a competing request meanwhile.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic sx, input logic [31:0] wd, input int bp,
                        output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          lat;
    @(negedge clk);
    req_wr       = wr;
    req_addr     = addr;
    req_size     = size;
    req_sign_ext = sx;
    req_wdata    = wd;
    req_valid    = 1'b1;
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      chk("busy_wait", busy, 1);
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("latency", lat, WAIT + 1);
    rd = rsp_rdata;
    er = rsp_err;
    model(wr, addr, size, sx, wd, exp_rd, exp_er);
    chk("rdata", rd, exp_rd);
    chk("err", er, exp_er);
    if (bp > 0) begin
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = $urandom_range(0, 191);
      req_size  = 2'd2;
      req_wdata = $urandom;
      for (int i = 0; i < bp; i++) begin
        @(posedge clk); #1;
        chk("bp_valid", rsp_valid, 1);
        chk("bp_rdata", rsp_rdata, rd);
        chk("bp_err", rsp_err, er);
        chk("bp_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      req_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("rsp_done", rsp_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] prior;
  logic [31:0] raddr;
  logic [1:0]  rsize;
  int          r;

  initial begin
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_wr       = 1'b0;
    req_addr     = 32'h0;
    req_size     = 2'd0;
    req_sign_ext = 1'b0;
    req_wdata    = 32'h0;
    rsp_ready    = 1'b1;
    for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h00;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", req_ready, 1);

    // Give the first 48 words known contents.
    for (int w = 0; w < 48; w++) do_txn(1'b1, 32'(4*w), 2'd2, 1'b0, $urandom, 0, rd, er);

    // Word store and load.
    do_txn(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, rd, er);
    chk("st_word_err", er, 0);
    do_txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, rd, er);
    chk("ld_word", rd, 32'hDEADBEEF);

    // Sub-word extension.
    do_txn(1'b1, 32'h80, 2'd2, 1'b0, 32'h80FF7F01, 0, rd, er);
    do_txn(1'b0, 32'h83, 2'd0, 1'b1, 32'h0, 0, rd, er);
    chk("ld_byte_sx", rd, 32'hFFFFFF80);
    do_txn(1'b0, 32'h83, 2'd0, 1'b0, 32'h0, 0, rd, er);
    chk("ld_byte_zx", rd, 32'h00000080);
    do_txn(1'b0, 32'h82, 2'd1, 1'b1, 32'h0, 0, rd, er);
    chk("ld_half_sx", rd, 32'hFFFF80FF);
    do_txn(1'b1, 32'h81, 2'd0, 1'b0, 32'h000000AA, 0, rd, er);
    do_txn(1'b0, 32'h80, 2'd2, 1'b0, 32'h0, 0, rd, er);
    chk("st_byte_merge", rd, 32'h80FFAA01);

    // Error cases.
    do_txn(1'b0, 32'h1000, 2'd2, 1'b0, 32'h0, 0, rd, er);
    chk("oob_err", er, 1);
    chk("oob_rdata", rd, 0);
    do_txn(1'b1, 32'h10, 2'd3, 1'b0, 32'h0, 0, rd, er);
    chk("size3_err", er, 1);
    do_txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, rd, er);
    chk("size3_nowrite", rd, 32'hDEADBEEF);
    do_txn(1'b0, 32'h12, 2'd2, 1'b0, 32'h0, 0, rd, er);
`ifdef NEWCELL_DMEM_MISALIGN_ERR_EN
    chk("misalign_err", er, 1);
`else
    chk("misalign_rdata", rd, 32'hDEADBEEF);
    chk("misalign_noerr", er, 0);
`endif

    // Backpressure with a competing request that must not be taken.
    do_txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 5, rd, er);
    chk("bp_ready_after", req_ready, 1);
    do_txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, rd, er);
    chk("bp_no_accept", rd, 32'hDEADBEEF);

    // Reset during the wait phase of a store.
    prior = {mb[32'h23], mb[32'h22], mb[32'h21], mb[32'h20]};
    @(negedge clk);
    req_wr    = 1'b1;
    req_addr  = 32'h20;
    req_size  = 2'd2;
    req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_busy", busy, 1);
    chk("abort_wait_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_busy_rst", busy, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_rsp", rsp_valid, 0);
    do_txn(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 0, rd, er);
    chk("abort_prior", rd, prior);

    // Random traffic within the known window plus occasional out-of-range addresses.
    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        raddr = $urandom;
        if (raddr < 32'(4*DEPTH)) raddr = raddr + 32'(4*DEPTH);
      end else begin
        raddr = $urandom_range(0, 191);
      end
      r = $urandom_range(0, 9);
      rsize = (r == 9) ? 2'd3 : 2'(r % 3);
      do_txn(1'($urandom_range(0, 1)), raddr, rsize, 1'($urandom_range(0, 1)), $urandom,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, rd, er);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
